// File: rtl/cnn_layer_accel_job_seq_pkg.sv
// Shared types and constants for the cnn_layer_accel job sequencer.
// State encodings are reported verbatim on err_state and must stay fixed.
package cnn_layer_accel_job_seq_pkg;

  localparam int C_DESC_W          = 128;
  localparam int C_DEFAULT_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_FETCH      = 3'd3,
    ST_RUN        = 3'd4,
    ST_ACK        = 3'd5
  } seq_state_e;

endpackage

// File: rtl/cnn_layer_accel_watchdog.sv
// Saturating per-state cycle counter; expired flags the last allowed cycle
// (count == limit-1) while enabled. A zero limit never expires.
module cnn_layer_accel_watchdog #(
  parameter int C_W = 20
) (
  input  logic           clk_if,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic [C_W-1:0] limit,
  output logic           expired
);

  logic [C_W-1:0] count_reg;

  always_ff @(posedge clk_if) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != '1)) begin
      count_reg <= count_reg + C_W'(1);
    end
  end

  assign expired = en && (limit != '0) && (count_reg == (limit - C_W'(1)));

endmodule

// File: rtl/cnn_layer_accel_job_sequencer.sv
// Walks one cnn_layer_accel_quad through start, fetch and completion handshakes
// for each host descriptor, aborting to IDLE if any wait state overstays.
module cnn_layer_accel_job_sequencer
  import cnn_layer_accel_job_seq_pkg::*;
#(
  parameter int C_TIMEOUT_W = 20,
  parameter int C_JOB_CNT_W = 16
) (
  input  logic                   clk_if,
  input  logic                   rst,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [C_DESC_W-1:0]    desc_data,
  input  logic [C_TIMEOUT_W-1:0] timeout_cfg,
  output logic                   job_start,
  input  logic                   job_accept,
  output logic [C_DESC_W-1:0]    job_parameters,
  input  logic                   job_fetch_request,
  output logic                   job_fetch_ack,
  input  logic                   job_fetch_complete,
  input  logic                   job_complete,
  output logic                   job_complete_ack,
  output logic                   busy,
  output logic [C_JOB_CNT_W-1:0] jobs_done,
  output logic                   err_timeout,
  output logic [2:0]             err_state,
  input  logic                   err_clr
);

  seq_state_e state_reg, state_next;

  logic                   desc_ready_reg, desc_ready_next;
  logic                   job_start_reg, job_start_next;
  logic                   job_fetch_ack_reg, job_fetch_ack_next;
  logic                   job_complete_ack_reg, job_complete_ack_next;
  logic                   busy_reg, busy_next;
  logic [C_DESC_W-1:0]    job_parameters_reg;
  logic [C_JOB_CNT_W-1:0] jobs_done_reg;
  logic                   err_timeout_reg;
  logic [2:0]             err_state_reg;

  logic desc_take, exit_cond, timeout_fire, job_retire;
  logic wd_clr, wd_en, wd_expired;

  assign desc_take  = desc_valid && desc_ready_reg;
  assign job_retire = (state_reg == ST_ACK) && !job_complete;

  // The event that lets each wait state advance; it beats a same-cycle expiry.
  always_comb begin
    exit_cond = 1'b0;
    case (state_reg)
      ST_START:      exit_cond = job_accept;
      ST_FETCH_WAIT: exit_cond = job_fetch_request;
      ST_FETCH:      exit_cond = job_fetch_complete;
      ST_RUN:        exit_cond = job_complete;
      default:       exit_cond = 1'b0;
    endcase
  end

  assign timeout_fire = wd_expired && !exit_cond;

  assign wd_en  = (state_reg == ST_START) || (state_reg == ST_FETCH_WAIT) ||
                  (state_reg == ST_FETCH) || (state_reg == ST_RUN);
  assign wd_clr = (state_next != state_reg) || !wd_en;

  cnn_layer_accel_watchdog #(
    .C_W (C_TIMEOUT_W)
  ) u_watchdog (
    .clk_if  (clk_if),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .limit   (timeout_cfg),
    .expired (wd_expired)
  );

  // State and registered outputs
  always_ff @(posedge clk_if) begin
    if (rst) begin
      state_reg            <= ST_IDLE;
      desc_ready_reg       <= 1'b0;
      job_start_reg        <= 1'b0;
      job_fetch_ack_reg    <= 1'b0;
      job_complete_ack_reg <= 1'b0;
      busy_reg             <= 1'b0;
      job_parameters_reg   <= '0;
      jobs_done_reg        <= '0;
      err_timeout_reg      <= 1'b0;
      err_state_reg        <= 3'd0;
    end else begin
      state_reg            <= state_next;
      desc_ready_reg       <= desc_ready_next;
      job_start_reg        <= job_start_next;
      job_fetch_ack_reg    <= job_fetch_ack_next;
      job_complete_ack_reg <= job_complete_ack_next;
      busy_reg             <= busy_next;
      if (desc_take) begin
        job_parameters_reg <= desc_data;
      end
      if (job_retire) begin
        jobs_done_reg <= jobs_done_reg + C_JOB_CNT_W'(1);
      end
      if (timeout_fire) begin
        err_timeout_reg <= 1'b1;
        err_state_reg   <= state_reg;
      end else if (err_clr) begin
        err_timeout_reg <= 1'b0;
        err_state_reg   <= 3'd0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (desc_take)          state_next = ST_START;
      ST_START:      if (job_accept)         state_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (job_fetch_request)  state_next = ST_FETCH;
      ST_FETCH:      if (job_fetch_complete) state_next = ST_RUN;
      ST_RUN:        if (job_complete)       state_next = ST_ACK;
      ST_ACK:        if (!job_complete)      state_next = ST_IDLE;
      default:                               state_next = ST_IDLE;
    endcase
    if (timeout_fire) begin
      state_next = ST_IDLE;
    end
  end

  // Outputs are decoded from the next state so they line up with state_reg.
  always_comb begin
    desc_ready_next       = (state_next == ST_IDLE);
    busy_next             = (state_next != ST_IDLE);
    job_start_next        = (state_next == ST_START);
    job_fetch_ack_next    = (state_reg == ST_FETCH_WAIT) && (state_next == ST_FETCH);
    job_complete_ack_next = (state_next == ST_ACK);
  end

  assign desc_ready       = desc_ready_reg;
  assign job_start        = job_start_reg;
  assign job_parameters   = job_parameters_reg;
  assign job_fetch_ack    = job_fetch_ack_reg;
  assign job_complete_ack = job_complete_ack_reg;
  assign busy             = busy_reg;
  assign jobs_done        = jobs_done_reg;
  assign err_timeout      = err_timeout_reg;
  assign err_state        = err_state_reg;

endmodule
